msrh_l1d_wb_receiver: RTL and testbench

L2-side responder for the L1D write-back request channel: accepts `M_XWR` line write requests, buffers them in an in-order FIFO, and drains them to the L2 data-array write port. Once each write completes, it can return a tagged acknowledgement. It also provides a combinational snoop port so a refill can read write-back data that is still pending. It sits between the L1D store-out path and the L2 array controller.

---
 rtl/msrh_l1d_wb_receiver_if.sv | 38 +++
 rtl/msrh_l1d_wb_receiver.sv | 190 +++++++++++++++++++
 tb/tb_msrh_l1d_wb_receiver.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrh_l1d_wb_receiver_if.sv
// Shared types and the L1D -> L2 request channel used by the write-back
// receiver: physical address width, cache line geometry, command encoding
// and the valid/ready request interface carrying one full line per beat.

package riscv_pkg;
  localparam int PADDR_W = 32;
endpackage

package msrh_conf_pkg;
  localparam int DCACHE_DATA_W = 512;
endpackage

package msrh_lsu_pkg;
  localparam int DCACHE_DATA_B_W = msrh_conf_pkg::DCACHE_DATA_W / 8;
  localparam int L2_CMD_TAG_W    = 8;

  typedef enum logic [4:0] {
    M_XRD = 5'b00000,
    M_XWR = 5'b00001
  } mem_cmd_t;

  typedef struct packed {
    mem_cmd_t                                 cmd;
    logic [riscv_pkg::PADDR_W-1:0]            addr;
    logic [L2_CMD_TAG_W-1:0]                  tag;
    logic [msrh_conf_pkg::DCACHE_DATA_W-1:0]  data;
    logic [DCACHE_DATA_B_W-1:0]               byte_en;
  } l2_req_t;
endpackage

interface l2_req_if;
  logic                  valid;
  logic                  ready;
  msrh_lsu_pkg::l2_req_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/msrh_l1d_wb_receiver.sv
// L2-side receiver for L1D line write-backs. Accepted M_XWR requests are
// queued in an in-order FIFO and drained to the L2 data-array write port.
// A combinational snoop port lets a refill pick up still-pending line data.
// Optional feature macro: MSRH_L2_WB_RESP_EN adds a one-deep tagged
// acknowledgement after each array write; without it the drain runs at one
// write per cycle and tags are dropped.

module msrh_l1d_wb_receiver #(
  parameter int ENTRIES = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset_n,
  l2_req_if.slave                                   l1d_ext_wr_req,
  output logic                                      o_mem_wr_valid,
  input  logic                                      i_mem_wr_ready,
  output logic [riscv_pkg::PADDR_W-1:0]             o_mem_wr_addr,
  output logic [msrh_conf_pkg::DCACHE_DATA_W-1:0]   o_mem_wr_data,
  output logic [msrh_lsu_pkg::DCACHE_DATA_B_W-1:0]  o_mem_wr_be,
  output logic                                      o_resp_valid,
  input  logic                                      i_resp_ready,
  output logic [msrh_lsu_pkg::L2_CMD_TAG_W-1:0]     o_resp_tag,
  input  logic [riscv_pkg::PADDR_W-1:0]             i_snoop_paddr,
  output logic                                      o_snoop_hit,
  output logic [msrh_conf_pkg::DCACHE_DATA_W-1:0]   o_snoop_data,
  output logic [msrh_lsu_pkg::DCACHE_DATA_B_W-1:0]  o_snoop_be,
  output logic                                      o_cmd_err,
  output logic                                      o_empty
);
  import msrh_lsu_pkg::*;

  localparam int PADDR_W = riscv_pkg::PADDR_W;
  localparam int DATA_W  = msrh_conf_pkg::DCACHE_DATA_W;
  localparam int BE_W    = msrh_lsu_pkg::DCACHE_DATA_B_W;
  localparam int OFF_W   = $clog2(BE_W);
  localparam int LINE_W  = PADDR_W - OFF_W;
  localparam int PTR_W   = $clog2(ENTRIES);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  // Entry storage: only the line address is kept, the offset is always zero.
  logic [LINE_W-1:0] line_q [ENTRIES];
  logic [DATA_W-1:0] data_q [ENTRIES];
  logic [BE_W-1:0]   be_q   [ENTRIES];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic accept;
  logic push;
  logic pop;
  logic resp_busy;
  logic cmd_err_q;

  // Ready depends on registered occupancy only, so a pop while full never
  // frees a slot for a push in the same cycle.
  assign empty                = (count_q == '0);
  assign l1d_ext_wr_req.ready = (count_q != FULL_CNT);
  assign accept               = l1d_ext_wr_req.valid & l1d_ext_wr_req.ready;
  assign push                 = accept & (l1d_ext_wr_req.payload.cmd == M_XWR);
  assign o_mem_wr_valid       = !empty & !resp_busy;
  assign pop                  = o_mem_wr_valid & i_mem_wr_ready;
  assign o_empty              = empty;
  assign o_cmd_err            = cmd_err_q;

  // Offset bits of both addresses are intentionally ignored.
  logic unused_offsets;
  assign unused_offsets = ^{l1d_ext_wr_req.payload.addr[OFF_W-1:0],
                            i_snoop_paddr[OFF_W-1:0]};

  // FIFO pointers and occupancy.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload written at the tail on every accepted write-back.
  // NOTE: the entry array has no reset; an entry is only read while the
  // occupancy says it is live, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      line_q[tail_q] <= l1d_ext_wr_req.payload.addr[PADDR_W-1:OFF_W];
      data_q[tail_q] <= l1d_ext_wr_req.payload.data;
      be_q[tail_q]   <= l1d_ext_wr_req.payload.byte_en;
    end
  end

  // One-cycle error pulse after a handshake that carried a non-write command.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= accept & (l1d_ext_wr_req.payload.cmd != M_XWR);
    end
  end

  // Array write port driven from the head entry, zero while nothing is queued.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held (no latch).
  always_comb begin
    o_mem_wr_addr = '0;
    o_mem_wr_data = '0;
    o_mem_wr_be   = '0;
    if (!empty) begin
      o_mem_wr_addr = {line_q[head_q], {OFF_W{1'b0}}};
      o_mem_wr_data = data_q[head_q];
      o_mem_wr_be   = be_q[head_q];
    end
  end

  // Snoop: scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    o_snoop_hit  = 1'b0;
    o_snoop_data = '0;
    o_snoop_be   = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (line_q[head_q + PTR_W'(k)] == i_snoop_paddr[PADDR_W-1:OFF_W])) begin
        o_snoop_hit  = 1'b1;
        o_snoop_data = data_q[head_q + PTR_W'(k)];
        o_snoop_be   = be_q[head_q + PTR_W'(k)];
      end
    end
  end

`ifdef MSRH_L2_WB_RESP_EN
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_e;

  logic [L2_CMD_TAG_W-1:0] tag_q [ENTRIES];
  logic [L2_CMD_TAG_W-1:0] resp_tag_q;
  resp_state_e             state_q;
  resp_state_e             state_d;

  // Tag storage alongside the entry payload.
  always_ff @(posedge i_clk) begin
    if (push) tag_q[tail_q] <= l1d_ext_wr_req.payload.tag;
  end

  // Response state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Response next state: a pop raises the acknowledgement, ready clears it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)          state_d = RESP;
      RESP:    if (i_resp_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Tag of the write just handed to the array, held until acknowledged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  resp_tag_q <= '0;
    else if (pop)    resp_tag_q <= tag_q[head_q];
  end

  assign resp_busy    = (state_q == RESP);
  assign o_resp_valid = resp_busy;
  assign o_resp_tag   = resp_tag_q;
`else
  assign resp_busy    = 1'b0;
  assign o_resp_valid = 1'b0;
  assign o_resp_tag   = '0;

  logic unused_resp;
  assign unused_resp = i_resp_ready ^ (^l1d_ext_wr_req.payload.tag);
`endif

endmodule

// File: tb/tb_msrh_l1d_wb_receiver.sv
// Self-checking bench for msrh_l1d_wb_receiver (ENTRIES = 4, 64-byte lines).
// Expected array writes and acknowledgement tags are queued when stimulus is
// driven and compared by a monitor when the DUT performs the handshake.
// Builds with or without MSRH_L2_WB_RESP_EN.
`timescale 1ns/1ps

module tb_msrh_l1d_wb_receiver;
  import msrh_lsu_pkg::*;

  localparam int ENTRIES = 4;
  localparam int PADDR_W = riscv_pkg::PADDR_W;
  localparam int DATA_W  = msrh_conf_pkg::DCACHE_DATA_W;
  localparam int BE_W    = msrh_lsu_pkg::DCACHE_DATA_B_W;
  localparam int TAG_W   = msrh_lsu_pkg::L2_CMD_TAG_W;
  localparam int OFF_W   = $clog2(BE_W);

  typedef struct {
    logic [PADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic [BE_W-1:0]    be;
    logic [TAG_W-1:0]   tag;
  } wr_exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               mem_wr_valid;
  logic               mem_wr_ready;
  logic [PADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0]  mem_wr_data;
  logic [BE_W-1:0]    mem_wr_be;
  logic               resp_valid;
  logic               resp_ready;
  logic [TAG_W-1:0]   resp_tag;
  logic [PADDR_W-1:0] snoop_paddr;
  logic               snoop_hit;
  logic [DATA_W-1:0]  snoop_data;
  logic [BE_W-1:0]    snoop_be;
  logic               cmd_err;
  logic               empty;

  l2_req_if req_if ();

  msrh_l1d_wb_receiver #(.ENTRIES(ENTRIES)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .l1d_ext_wr_req (req_if),
    .o_mem_wr_valid (mem_wr_valid),
    .i_mem_wr_ready (mem_wr_ready),
    .o_mem_wr_addr  (mem_wr_addr),
    .o_mem_wr_data  (mem_wr_data),
    .o_mem_wr_be    (mem_wr_be),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_tag     (resp_tag),
    .i_snoop_paddr  (snoop_paddr),
    .o_snoop_hit    (snoop_hit),
    .o_snoop_data   (snoop_data),
    .o_snoop_be     (snoop_be),
    .o_cmd_err      (cmd_err),
    .o_empty        (empty)
  );

  always #5 clk = ~clk;

  wr_exp_t          sb[$];
  logic [TAG_W-1:0] rq[$];
  int checks  = 0;
  int errors  = 0;
  int pop_cnt = 0;

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] seed);
    return {(DATA_W/32){seed}};
  endfunction

  function automatic logic [BE_W-1:0] mk_be(input logic [31:0] seed);
    return {(BE_W/32){seed ^ 32'h0F0F_F0F0}};
  endfunction

  // Inputs change 1 ns after the rising edge; outputs are read there or later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at the falling edge the inputs for the next rising edge are final.
  always @(negedge clk) begin : monitor
    wr_exp_t e;
    if (reset_n && mem_wr_valid && mem_wr_ready) begin
      checks++;
      pop_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h, no write expected", mem_wr_addr);
      end else begin
        e = sb.pop_front();
        if (mem_wr_addr !== e.addr || mem_wr_data !== e.data || mem_wr_be !== e.be) begin
          errors++;
          $display("FAIL write_content: got addr %h data[31:0] %h be %h, expected addr %h data[31:0] %h be %h",
                   mem_wr_addr, mem_wr_data[31:0], mem_wr_be, e.addr, e.data[31:0], e.be);
        end
`ifdef MSRH_L2_WB_RESP_EN
        rq.push_back(e.tag);
`endif
      end
    end
`ifdef MSRH_L2_WB_RESP_EN
    if (reset_n && resp_valid && resp_ready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got tag %h, no response expected", resp_tag);
      end else begin
        if (resp_tag !== rq[0]) begin
          errors++;
          $display("FAIL resp_tag: got %h expected %h", resp_tag, rq[0]);
        end
        void'(rq.pop_front());
      end
    end
`endif
  end

  // Present one request for one cycle and check the ready the bench expects.
  task automatic drive_req(input mem_cmd_t cmd, input logic [PADDR_W-1:0] addr,
                           input logic [TAG_W-1:0] tag, input logic [31:0] seed,
                           input logic exp_ready, input string name);
    wr_exp_t e;
    req_if.valid           = 1'b1;
    req_if.payload.cmd     = cmd;
    req_if.payload.addr    = addr;
    req_if.payload.tag     = tag;
    req_if.payload.data    = mk_data(seed);
    req_if.payload.byte_en = mk_be(seed);
    #1;
    checks++;
    if (req_if.ready !== exp_ready) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, req_if.ready, exp_ready);
    end
    if (exp_ready && cmd == M_XWR) begin
      e.addr = {addr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      e.data = mk_data(seed);
      e.be   = mk_be(seed);
      e.tag  = tag;
      sb.push_back(e);
    end
    tick();
    req_if.valid = 1'b0;
  endtask

  // Let everything queued reach the array and be acknowledged.
  task automatic drain(input int budget, input string name);
    mem_wr_ready = 1'b1;
    resp_ready   = 1'b1;
    for (int i = 0; i < budget && (sb.size() != 0 || rq.size() != 0); i++) tick();
    checks++;
    if (sb.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes and %0d responses outstanding, expected 0",
               name, sb.size(), rq.size());
    end
    checks++;
    if (empty !== 1'b1 || req_if.ready !== 1'b1 || mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got empty %b ready %b wr_valid %b, expected 1 1 0",
               name, empty, req_if.ready, mem_wr_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_if.ready !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_empty: got ready %b empty %b, expected 1 1", req_if.ready, empty);
    end
    checks++;
    if (mem_wr_valid !== 1'b0 || resp_valid !== 1'b0 || snoop_hit !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: got wr %b resp %b hit %b err %b, expected 0 0 0 0",
               mem_wr_valid, resp_valid, snoop_hit, cmd_err);
    end
    checks++;
    if (mem_wr_addr !== '0 || mem_wr_data !== '0 || mem_wr_be !== '0 || resp_tag !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h tag %h, expected all outputs zero", mem_wr_addr, resp_tag);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem_wr_ready = 1'b1;
    resp_ready   = 1'b1;
    drive_req(M_XWR, 32'h8000_0040, 8'h2A, 32'h1111_0001, 1'b1, "single");
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h8000_0040) begin
      errors++;
      $display("FAIL single_wr_latency: got valid %b addr %h, expected 1 80000040", mem_wr_valid, mem_wr_addr);
    end
    tick();
`ifdef MSRH_L2_WB_RESP_EN
    checks++;
    if (resp_valid !== 1'b1 || resp_tag !== 8'h2A) begin
      errors++;
      $display("FAIL single_resp_latency: got valid %b tag %h, expected 1 2a", resp_valid, resp_tag);
    end
`else
    checks++;
    if (resp_valid !== 1'b0 || resp_tag !== '0) begin
      errors++;
      $display("FAIL single_resp_off: got valid %b tag %h, expected 0 00", resp_valid, resp_tag);
    end
`endif
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: got %b expected 1", empty);
    end
    drain(10, "single");
  endtask

  task automatic test_fill();
    mem_wr_ready = 1'b0;
    resp_ready   = 1'b1;
    for (int i = 0; i < 5; i++)
      drive_req(M_XWR, 32'h1000_0000 + 32'(i * 64), TAG_W'(8'h10 + i), 32'h0000_0100 + 32'(i),
                (i < 4), "fill");
    checks++;
    if (req_if.ready !== 1'b0 || mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL fill_full: got ready %b wr_valid %b addr %h, expected 0 1 10000000",
               req_if.ready, mem_wr_valid, mem_wr_addr);
    end
    repeat (2) tick();
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h1000_0000 || mem_wr_data !== mk_data(32'h100)) begin
      errors++;
      $display("FAIL fill_hold: got valid %b addr %h, expected 1 10000000 held", mem_wr_valid, mem_wr_addr);
    end
    drain(40, "fill");
  endtask

  task automatic test_full_pop();
    mem_wr_ready = 1'b0;
    resp_ready   = 1'b1;
    for (int i = 0; i < 4; i++)
      drive_req(M_XWR, 32'h2000_0000 + 32'(i * 64), TAG_W'(8'h20 + i), 32'h0000_0200 + 32'(i),
                1'b1, "full_pop_fill");
    mem_wr_ready = 1'b1;
    drive_req(M_XWR, 32'h2000_1000, 8'h2F, 32'hDEAD_0000, 1'b0, "full_pop_refuse");
    checks++;
    if (req_if.ready !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_count3: got ready %b empty %b, expected 1 0", req_if.ready, empty);
    end
    drain(40, "full_pop");
  endtask

  task automatic test_snoop();
    wr_exp_t e;
    mem_wr_ready = 1'b0;
    resp_ready   = 1'b1;
    drive_req(M_XWR, 32'h0000_0100, 8'h31, 32'hAAAA_0001, 1'b1, "snoop_a");
    drive_req(M_XWR, 32'h0000_0200, 8'h32, 32'hBBBB_0002, 1'b1, "snoop_b");
    req_if.valid           = 1'b1;
    req_if.payload.cmd     = M_XWR;
    req_if.payload.addr    = 32'h0000_0100;
    req_if.payload.tag     = 8'h33;
    req_if.payload.data    = mk_data(32'hCCCC_0003);
    req_if.payload.byte_en = mk_be(32'hCCCC_0003);
    snoop_paddr            = 32'h0000_013C;
    #1;
    checks++;
    if (snoop_hit !== 1'b1 || snoop_data !== mk_data(32'hAAAA_0001)) begin
      errors++;
      $display("FAIL snoop_same_cycle_push: got hit %b data[31:0] %h, expected 1 aaaa0001",
               snoop_hit, snoop_data[31:0]);
    end
    e.addr = 32'h0000_0100;
    e.data = mk_data(32'hCCCC_0003);
    e.be   = mk_be(32'hCCCC_0003);
    e.tag  = 8'h33;
    sb.push_back(e);
    tick();
    req_if.valid = 1'b0;
    #1;
    checks++;
    if (snoop_hit !== 1'b1 || snoop_data !== mk_data(32'hCCCC_0003) || snoop_be !== mk_be(32'hCCCC_0003)) begin
      errors++;
      $display("FAIL snoop_youngest: got hit %b data[31:0] %h be %h, expected 1 cccc0003 %h",
               snoop_hit, snoop_data[31:0], snoop_be, mk_be(32'hCCCC_0003));
    end
    snoop_paddr = 32'h0000_023F;
    #1;
    checks++;
    if (snoop_hit !== 1'b1 || snoop_data !== mk_data(32'hBBBB_0002)) begin
      errors++;
      $display("FAIL snoop_b: got hit %b data[31:0] %h, expected 1 bbbb0002", snoop_hit, snoop_data[31:0]);
    end
    snoop_paddr = 32'h0000_0300;
    #1;
    checks++;
    if (snoop_hit !== 1'b0) begin
      errors++;
      $display("FAIL snoop_miss: got hit %b expected 0", snoop_hit);
    end
    drain(40, "snoop");
  endtask

`ifdef MSRH_L2_WB_RESP_EN
  task automatic test_resp_backpressure();
    int base;
    mem_wr_ready = 1'b0;
    resp_ready   = 1'b0;
    drive_req(M_XWR, 32'h3000_0000, 8'h41, 32'h0000_0301, 1'b1, "bp_a");
    drive_req(M_XWR, 32'h3000_0040, 8'h42, 32'h0000_0302, 1'b1, "bp_b");
    mem_wr_ready = 1'b1;
    base = pop_cnt;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_wr_valid !== 1'b0 || resp_valid !== 1'b1 || resp_tag !== 8'h41) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d: got wr_valid %b resp_valid %b tag %h, expected 0 1 41",
                 i, mem_wr_valid, resp_valid, resp_tag);
      end
      tick();
    end
    checks++;
    if (pop_cnt !== base + 1) begin
      errors++;
      $display("FAIL bp_writes: got %0d writes expected %0d", pop_cnt - base, 1);
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h3000_0040) begin
      errors++;
      $display("FAIL bp_release: got wr_valid %b addr %h, expected 1 30000040", mem_wr_valid, mem_wr_addr);
    end
    drain(20, "bp");
  endtask
`else
  task automatic test_back_to_back();
    int base;
    mem_wr_ready = 1'b0;
    drive_req(M_XWR, 32'h3000_0000, 8'h41, 32'h0000_0301, 1'b1, "b2b_a");
    drive_req(M_XWR, 32'h3000_0040, 8'h42, 32'h0000_0302, 1'b1, "b2b_b");
    mem_wr_ready = 1'b1;
    base = pop_cnt;
    tick();
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h3000_0040 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_next_cycle: got wr_valid %b addr %h resp %b, expected 1 30000040 0",
               mem_wr_valid, mem_wr_addr, resp_valid);
    end
    tick();
    checks++;
    if (pop_cnt !== base + 2 || empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rate: got %0d writes empty %b, expected 2 1", pop_cnt - base, empty);
    end
    drain(10, "b2b");
  endtask
`endif

  task automatic test_cmd_err();
    mem_wr_ready = 1'b0;
    drive_req(M_XRD, 32'h8000_1000, 8'h51, 32'h0000_0401, 1'b1, "cmd_err");
    checks++;
    if (cmd_err !== 1'b1 || empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL cmd_err_pulse: got err %b empty %b wr_valid %b, expected 1 1 0",
               cmd_err, empty, mem_wr_valid);
    end
    tick();
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL cmd_err_one_cycle: got %b expected 0", cmd_err);
    end
  endtask

  task automatic test_reset_mid();
    mem_wr_ready = 1'b0;
    resp_ready   = 1'b1;
    for (int i = 0; i < 3; i++)
      drive_req(M_XWR, 32'h4000_0000 + 32'(i * 64), TAG_W'(8'h60 + i), 32'h0000_0500 + 32'(i),
                1'b1, "rst_fill");
    snoop_paddr = 32'h4000_0000;
    reset_n     = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || mem_wr_valid !== 1'b0 || resp_valid !== 1'b0 || snoop_hit !== 1'b0 ||
        req_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got empty %b wr %b resp %b hit %b ready %b, expected 1 0 0 0 1",
               empty, mem_wr_valid, resp_valid, snoop_hit, req_if.ready);
    end
    sb.delete();
    rq.delete();
    tick();
    reset_n      = 1'b1;
    mem_wr_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (empty !== 1'b1 || mem_wr_valid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got empty %b wr %b resp %b, expected 1 0 0",
               empty, mem_wr_valid, resp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_if.valid   = 1'b0;
    req_if.payload = '0;
    mem_wr_ready   = 1'b0;
    resp_ready     = 1'b1;
    snoop_paddr    = '0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_snoop();
`ifdef MSRH_L2_WB_RESP_EN
    test_resp_backpressure();
`else
    test_back_to_back();
`endif
    test_cmd_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
